// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder/subtractor. An operation is accepted in IDLE, processed
//   DIGIT bits per cycle for STEPS = WIDTH/DIGIT cycles in RUN, and the result
//   is presented in DONE until the consumer takes it.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready is high only in IDLE and out_valid only in DONE;
//   once raised, out_valid and the result stay stable until out_ready is seen.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block accepts operands (state == IDLE)
//   a, b       operands, WIDTH bits
//   cin        carry in (add) / borrow in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid (state == DONE)
//   out_ready  consumer accepts result
//   sum        registered result, WIDTH bits
//   cout       registered final carry (add) or NOT borrow (sub)
//   ovf        registered two's-complement overflow
//   busy       high in RUN or DONE
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_adder: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic [WIDTH-1:0] a_nx;
    logic             last_step;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign last_step = (cnt == LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // Digit datapath
    // ------------------------------------------------------------------
    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of this digit; on the final step this is the
    // carry into the result MSB, needed for the overflow flag.
    assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    // The a register doubles as the partial-sum shifter: as operand digits
    // leave at the bottom, result digits enter at the top, so after STEPS
    // shifts it holds the complete sum.
    generate
        if (DIGIT == WIDTH) begin : g_one_step
            assign a_nx = dsum[DIGIT-1:0];
        end else begin : g_multi_step
            assign a_nx = {dsum[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                // Subtraction as a + ~b + ~cin, i.e. a - b - cin.
                a_q   <= a;
                b_q   <= sub ? ~b : b;
                carry <= cin ^ sub;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_q   <= a_nx;
            b_q   <= b_q >> DIGIT;
            carry <= dsum[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                sum  <= a_nx;
                cout <= dsum[DIGIT];
                ovf  <= msb_cin ^ dsum[DIGIT];
            end
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand/result width in bits; legal values are WIDTH >= 2.
REQ-002 SHALL provide parameter DIGIT, default 1: bits processed per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0. Elaboration SHALL fail on an illegal value.
REQ-003 SHALL define derived constant STEPS = WIDTH/DIGIT.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block accepts operands.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 cin  input  1  carry in for add; borrow in for sub.
REQ-011 sub  input  1  mode select: 0 = a+b+cin, 1 = a-b-cin.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result, registered.
REQ-015 cout  output  1  final carry (add) or NOT borrow (sub), registered.
REQ-016 ovf  output  1  two's-complement overflow, registered.
REQ-017 busy  output  1  high in RUN or DONE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 IDLE, in_valid&in_ready at an edge: capture a; capture b, inverted when sub=1; initialise carry = cin XOR sub; clear step counter; go to RUN.
REQ-020 RUN: each cycle add the DIGIT LSBs of the operand registers and the carry; shift the operand registers right by DIGIT; shift the partial sum in from the MSB side; update carry; increment the counter.
REQ-021 On completion of step STEPS: load sum, cout = final carry, ovf = carry into MSB XOR carry out of MSB; go to DONE.
REQ-022 Latency: out_valid SHALL rise on the STEPS-th rising edge after the accepting edge. DIGIT=WIDTH gives a single RUN cycle.
REQ-023 DONE: sum/cout/ovf/out_valid SHALL hold stable until out_valid&out_ready; on that edge go to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; no operand capture and no queuing.
REQ-025 a/b/cin/sub changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-026 sum/cout/ovf SHALL retain the last result in IDLE and RUN until overwritten by REQ-021.
REQ-027 Back-to-back operation: in_ready is high the cycle after the output handshake; maximum throughput is one operation per STEPS+2 cycles.
REQ-028 The result SHALL equal (a + b + cin) mod 2^WIDTH, or (a - b - cin) mod 2^WIDTH, bit-exact for all inputs and every legal DIGIT.

Reset
REQ-029 rst high SHALL immediately force state=IDLE and zero the counter, the carry, the operand registers, sum, cout and ovf.
REQ-030 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
REQ-031 rst asserted mid-RUN or in DONE SHALL abort the operation with no result produced; the first operation after rst deasserts SHALL be unaffected.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-032 Add case: a=0x0F, b=0x01, cin=0, sub=0 -> after 8 cycles out_valid=1, sum=0x10, cout=0, ovf=0.
REQ-033 Signed overflow: a=0x7F, b=0x01 add -> sum=0x80, cout=0, ovf=1. Carry with wrap: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-034 Subtract: a=0x00, b=0x01, sub=1, cin=0 -> sum=0xFF, cout=0, ovf=0. Subtract with borrow-in: a=0x80, b=0x01, sub=1, cin=1 -> sum=0x7E, cout=1, ovf=1.
REQ-035 Backpressure: out_ready held low 5 cycles in DONE with in_valid=1 and operands toggling -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-RUN after step 4 -> out_valid never asserts, in_ready=1 and all outputs 0; the next operation 0x03+0x04 -> sum=0x07.
REQ-037 WIDTH=16, DIGIT=4: 0xFFFF+0x0001 -> out_valid 4 cycles after accept, sum=0x0000, cout=1; random check of 10k vectors against the arithmetic model for DIGIT in {1,2,4,8,16}.
